// File: rtl/fare_code_sender.sv
// ============================================================================
// Module   : fare_code_sender
// Purpose  : Sends a latched fare code digit-by-digit to the turnstile
//            controller, waits for the door response, retries on timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fare_code_sender #(
  parameter int NUM_DIGITS = 3,
  parameter int TIMEOUT    = 8,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_RETRY  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_valid,
  input  logic [4*NUM_DIGITS-1:0] card_code,
  input  logic                    open_access_door,
  output logic                    card_ready,
  output logic                    valid_code,
  output logic [3:0]              access_code,
  output logic                    grant,
  output logic                    deny,
  output logic [1:0]              state_out
);

  localparam int CW  = 4 * NUM_DIGITS;
  localparam int TOP = 4 * (NUM_DIGITS - 1);
  localparam int DW  = $clog2(NUM_DIGITS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] c_NUM_DIGITS = DW'(NUM_DIGITS);
  localparam logic [TW-1:0] c_TIMEOUT    = TW'(TIMEOUT);
  localparam logic [GW-1:0] c_GAP_CYCLES = GW'(GAP_CYCLES);
  localparam logic [RW-1:0] c_MAX_RETRY  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10,
    GAP  = 2'b11
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_code;
  logic [CW-1:0]   r_shift;
  logic [DW-1:0]   r_dig_cnt;
  logic [TW-1:0]   r_timer;
  logic [GW-1:0]   r_gap_cnt;
  logic [RW-1:0]   r_retry;
  logic            r_resend;

  assign card_ready = (r_state == IDLE);
  assign state_out  = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_code      <= '0;
      r_shift     <= '0;
      r_dig_cnt   <= '0;
      r_timer     <= '0;
      r_gap_cnt   <= '0;
      r_retry     <= '0;
      r_resend    <= 1'b0;
      valid_code  <= 1'b0;
      access_code <= 4'h0;
      grant       <= 1'b0;
      deny        <= 1'b0;
    end else begin
      grant <= 1'b0;
      deny  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (card_valid) begin
            r_code      <= card_code;
            r_shift     <= card_code << 4;
            r_dig_cnt   <= DW'(1);
            r_retry     <= c_MAX_RETRY;
            valid_code  <= 1'b1;
            access_code <= card_code[TOP +: 4];
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (r_dig_cnt == c_NUM_DIGITS) begin
            valid_code  <= 1'b0;
            access_code <= 4'h0;
            r_timer     <= TW'(1);
            r_state     <= WAIT;
          end else begin
            access_code <= r_shift[CW-1 -: 4];
            r_shift     <= r_shift << 4;
            r_dig_cnt   <= r_dig_cnt + 1'b1;
          end
        end
        WAIT: begin
          // a door response on the final timer cycle still counts as a grant
          if (open_access_door) begin
            grant     <= 1'b1;
            r_resend  <= 1'b0;
            r_gap_cnt <= GW'(1);
            r_state   <= GAP;
          end else if (r_timer == c_TIMEOUT) begin
            if (r_retry != '0) begin
              r_retry  <= r_retry - 1'b1;
              r_resend <= 1'b1;
            end else begin
              deny     <= 1'b1;
              r_resend <= 1'b0;
            end
            r_gap_cnt <= GW'(1);
            r_state   <= GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          if (r_gap_cnt == c_GAP_CYCLES) begin
            if (r_resend) begin
              r_shift     <= r_code << 4;
              r_dig_cnt   <= DW'(1);
              valid_code  <= 1'b1;
              access_code <= r_code[TOP +: 4];
              r_resend    <= 1'b0;
              r_state     <= SEND;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fare_code_sender.md
Name: fare_code_sender

Overview:
- Initiator side of the turnstile access-code interface: takes a complete fare code from the card reader and sends it to the turnstile access controller, one 4-bit digit per clock on access_code, qualified by valid_code.
- Watches the controller's open_access_door response and reports the result to the reader as grant or deny.
- Retries a timed-out attempt a bounded number of times.
- Sits between the card-reader front end and the turnstile controller FSM, on the same clock.

Parameters:
- NUM_DIGITS, 3, number of 4-bit digits per fare code; most-significant digit is sent first.
- TIMEOUT, 8, WAIT cycles allowed for open_access_door before the attempt fails (>=1).
- GAP_CYCLES, 2, idle cycles with valid_code=0 after every attempt, so the controller returns to its idle state (>=1).
- MAX_RETRY, 1, extra send attempts after a timeout before deny (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- card_valid  input  1  reader presents a new code; accepted only when card_ready=1.
- card_code  input  4*NUM_DIGITS  fare code; digit k is bits [4k+3:4k].
- open_access_door  input  1  controller response; sampled only in WAIT.
- card_ready  output  1  block idle and able to accept a card.
- valid_code  output  1  access_code carries a digit this cycle.
- access_code  output  4  current digit.
- grant  output  1  one-cycle pulse: door opened.
- deny  output  1  one-cycle pulse: all attempts timed out.
- state_out  output  2  current state (IDLE=00, SEND=01, WAIT=10, GAP=11).

Behaviour:
- Reset (reset=0, asynchronous) forces IDLE immediately. Reset values: valid_code=0, access_code=0, grant=0, deny=0, card_ready=1, state_out=00; the latched code, digit counter, timer and retry count are cleared. Reset asserted mid-attempt aborts it silently, with no grant or deny.
- All outputs except card_ready are registered. card_ready = (state==IDLE).
- IDLE: if card_valid=1 at posedge T0, card_code is latched and the state moves to SEND.
- IDLE: card_valid in any other state is ignored and the code is not queued.
- SEND lasts exactly NUM_DIGITS cycles (T0+1 .. T0+NUM_DIGITS).
  - valid_code=1 throughout.
  - access_code = digit NUM_DIGITS-1-k in SEND cycle k.
  - open_access_door is ignored during SEND.
- WAIT: valid_code=0, access_code=0.
  - The timer counts WAIT cycles, 1..TIMEOUT.
  - open_access_door=1 sampled at the posedge ending any WAIT cycle -> go to GAP with grant=1 in the first GAP cycle.
  - No door by the end of WAIT cycle TIMEOUT, with retries remaining -> decrement the retry count, go to GAP with no pulse, then re-enter SEND with the same latched code.
  - No door by the end of WAIT cycle TIMEOUT, with no retries remaining -> go to GAP with deny=1 in the first GAP cycle.
  - Door asserted in the same cycle the timer expires: grant wins.
- GAP: valid_code=0 for GAP_CYCLES cycles, then go to IDLE, or to SEND after a retry. open_access_door is ignored during GAP.
- Retry count reloads to MAX_RETRY on each accepted card.
- grant and deny are never both 1 in the same cycle. Exactly one grant or one deny is issued per accepted card, unless reset intervenes.
- Timer and counter widths are derived with $clog2 and must not wrap within a legal parameter range.

Test Plan:
1. Reset low at t=0, released at 2.5 time units -> valid_code=0, access_code=0, card_ready=1, state_out=00 while low and after release.
2. card_code=12'h009, card_valid=1 at T0 -> valid_code=1 with access_code 0,0,9 in T0+1..T0+3; valid_code=0 at T0+4; door=1 sampled in the 2nd WAIT cycle (T0+5) -> grant=1 at T0+6 only; card_ready=1 at T0+8.
3. card_code=12'h3A5, door never asserted, MAX_RETRY=1 -> digits 3,A,5 at T0+1..3; WAIT T0+4..11; GAP T0+12..13; resend 3,A,5 at T0+14..16; WAIT T0+17..24; deny=1 at T0+25 only; card_ready=1 at T0+27.
4. Door held high during SEND and GAP with no door in WAIT -> no grant; attempt times out as in scenario 3.
5. card_valid pulsed with code 12'h111 during SEND of code 12'h009 -> ignored; only 0,0,9 sent; no second attempt afterwards.
6. reset driven low at T0+2 mid-SEND -> valid_code=0 and state_out=00 immediately; no grant/deny; next card after release is sent correctly from its first digit.
